wm_embed_pipe: RTL

WM_EMBED_PIPE -- requirements
Module: wm_embed_pipe

---
 rtl/wm_embed_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/wm_embed_pipe.sv
// Two-stage watermark embedder: S1 averages the input channels and grabs LFSR
// watermark bits, S2 inserts them into the pixel according to the sample's mode.
module wm_embed_pipe #(
   parameter int          PIX_W     = 8,
   parameter int          NCH       = 4,
   parameter int          WM_BITS   = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NCH*PIX_W-1:0]   pix_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PIX_W-1:0]       pix_out,
   output logic [WM_BITS-1:0]     wm_out,
   output logic [15:0]            sample_cnt
);

   localparam int          LOG_NCH = $clog2(NCH);
   localparam int          SUM_W   = PIX_W + LOG_NCH;
   localparam logic [15:0] SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic                 s1_vld_q, s1_vld_d;
   logic [PIX_W-1:0]     s1_avg_q, s1_avg_d;
   logic [WM_BITS-1:0]   s1_wm_q, s1_wm_d;
   logic [1:0]           s1_mode_q, s1_mode_d;
   logic                 s2_vld_q, s2_vld_d;
   logic [PIX_W-1:0]     pix_q, pix_d;
   logic [WM_BITS-1:0]   wm_q, wm_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [15:0]          sample_cnt_q, sample_cnt_d;

   logic [SUM_W-1:0]     sum;
   logic [PIX_W-1:0]     avg;
   logic [PIX_W-1:0]     ins_pix;
   logic                 fb;
   logic                 s2_load;
   logic                 in_xfer;
   logic                 out_xfer;

   // Sum is wide enough for NCH full-scale channels, so the shift never overflows.
   always_comb begin
      sum = '0;
      for (int k = 0; k < NCH; k++)
         sum = sum + SUM_W'(pix_in[k*PIX_W +: PIX_W]);
      avg = sum[SUM_W-1:LOG_NCH];
   end

   always_comb begin
      case (s1_mode_q)
         2'b01:   ins_pix = {s1_avg_q[PIX_W-1:WM_BITS], s1_wm_q};
         2'b10:   ins_pix = s1_avg_q ^ PIX_W'(s1_wm_q);
         default: ins_pix = s1_avg_q;
      endcase
   end

   assign fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign out_xfer = s2_vld_q & out_ready;
   assign s2_load  = s1_vld_q & (~s2_vld_q | out_ready);
   assign in_ready = ~rst & (~s1_vld_q | s2_load);
   assign in_xfer  = in_valid & in_ready;

   always_comb begin
      s1_vld_d     = in_xfer | (s1_vld_q & ~s2_load);
      s1_avg_d     = s1_avg_q;
      s1_wm_d      = s1_wm_q;
      s1_mode_d    = s1_mode_q;
      lfsr_d       = lfsr_q;
      s2_vld_d     = s2_load | (s2_vld_q & ~out_ready);
      pix_d        = pix_q;
      wm_d         = wm_q;
      sample_cnt_d = sample_cnt_q + {15'd0, out_xfer};
      if (in_xfer) begin
         s1_avg_d  = avg;
         s1_wm_d   = lfsr_q[WM_BITS-1:0];
         s1_mode_d = mode;
         lfsr_d    = {lfsr_q[14:0], fb};
      end
      if (s2_load) begin
         pix_d = ins_pix;
         wm_d  = s1_wm_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q     <= 1'b0;
         s1_avg_q     <= '0;
         s1_wm_q      <= '0;
         s1_mode_q    <= 2'b00;
         s2_vld_q     <= 1'b0;
         pix_q        <= '0;
         wm_q         <= '0;
         lfsr_q       <= SEED;
         sample_cnt_q <= 16'd0;
      end else begin
         s1_vld_q     <= s1_vld_d;
         s1_avg_q     <= s1_avg_d;
         s1_wm_q      <= s1_wm_d;
         s1_mode_q    <= s1_mode_d;
         s2_vld_q     <= s2_vld_d;
         pix_q        <= pix_d;
         wm_q         <= wm_d;
         lfsr_q       <= lfsr_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

   assign out_valid  = s2_vld_q;
   assign pix_out    = pix_q;
   assign wm_out     = wm_q;
   assign sample_cnt = sample_cnt_q;

endmodule
